// File: rtl/tdm_mult_scheduler.sv
// tdm_mult_scheduler: round-robin issue of operand pairs from NUM_REQ requesters
// onto one shared, non-stallable pipelined multiplier. Issue is gated by
// downstream FIFO credits, and a RUN -> DRAIN -> DONE sequence quiesces the
// datapath before reconfiguration.
module tdm_mult_scheduler #(
  parameter int  NUM_REQ      = 2,
  parameter int  DATA_WIDTH   = 8,
  parameter int  MULT_LATENCY = 4,
  parameter int  CREDITS      = 8,
  localparam int ID_W         = $clog2(NUM_REQ),
  localparam int CW           = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         mult_a,
  output logic [DATA_WIDTH-1:0]         mult_b,
  output logic                          issue_valid,
  input  logic [2*DATA_WIDTH-1:0]       mult_p,
  output logic                          res_valid,
  output logic [ID_W-1:0]               res_id,
  output logic [2*DATA_WIDTH-1:0]       res_data,
  input  logic                          credit_return,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [CW-1:0]                 credits_avail,
  output logic                          err_credit_ovf
);

  localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0]   CRED_ONE = CW'(1);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         winner;
  logic                    any_valid;
  logic                    can_issue;
  logic                    xfer;
  logic [CW-1:0]           credits;
  logic                    credit_ovf;
  logic [ID_W-1:0]         issue_id_p0;
  logic [MULT_LATENCY-1:0] tag_vld_p;
  logic [ID_W-1:0]         tag_id_p [MULT_LATENCY];

  // Saturating credit update: a take and a give in the same cycle cancel out.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic take, input logic give);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (take && !give)
      nxt = cur - CRED_ONE;
    else if (give && !take && cur != CRED_MAX)
      nxt = cur + CRED_ONE;
    return nxt;
  endfunction

  // Round-robin winner: first valid requester at or after ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Grant only while running, not on the first flush_req cycle, and with a credit.
  always_comb begin
    can_issue = (state == RUN) && !flush_req && (credits != '0);
    xfer      = can_issue && any_valid;
    req_ready = '0;
    if (xfer) req_ready[winner] = 1'b1;
  end

  assign credit_ovf    = credit_return && !xfer && (credits == CRED_MAX);
  assign credits_avail = credits;
  assign res_valid     = tag_vld_p[MULT_LATENCY-1];
  assign res_id        = tag_id_p[MULT_LATENCY-1];
  assign res_data      = mult_p;

  // Arbitration pointer, credit counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= '0;
      credits        <= CRED_MAX;
      err_credit_ovf <= 1'b0;
    end else begin
      credits <= credit_next(credits, xfer, credit_return);
      if (credit_ovf) err_credit_ovf <= 1'b1;
      if (xfer) ptr <= (winner == ID_LAST) ? '0 : winner + ID_W'(1);
    end
  end

  // Issue stage: operands hold their last value when nothing is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_id_p0 <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
    end else begin
      issue_valid <= xfer;
      if (xfer) begin
        issue_id_p0 <= winner;
        mult_a      <= req_a[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        mult_b      <= req_b[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Tag pipe: follows the multiplier so res_id lines up with mult_p.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) tag_id_p[i] <= '0;
    end else begin
      tag_vld_p[0] <= issue_valid;
      tag_id_p[0]  <= issue_id_p0;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_id_p[i]  <= tag_id_p[i-1];
      end
    end
  end

  // Flush sequencing; DONE is left only once flush_req has dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!issue_valid && (tag_vld_p == '0)) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          if (!flush_req) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
